// File: rtl/dist_pkg.sv
// Shared constants, state encoding and result bundle for the shared serial divider.
// Imported by the interface, the divider core and the arbiter top.
package dist_pkg;

  localparam int DVD_W    = 32;
  localparam int DVS_W    = 16;
  localparam int QUO_W    = 16;
  localparam int DIV_ITER = 32;
  localparam int CNT_W    = $clog2(DIV_ITER + 1);

  localparam logic [QUO_W-1:0] QUO_SAT = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic [QUO_W-1:0] quotient;
    logic [DVS_W-1:0] remainder;
    logic             div_zero;
    logic             ovf;
  } div_result_t;

endpackage

// File: rtl/div_share_arbiter_if.sv
// Request/ack operand handoff and shared result return between the channels
// and the divider arbiter.
interface div_share_arbiter_if
  import dist_pkg::*;
#(
  parameter int N_REQ = 4
);

  logic [N_REQ-1:0]       i_req;
  logic [N_REQ*DVD_W-1:0] i_dividend;
  logic [N_REQ*DVS_W-1:0] i_divisor;
  logic [N_REQ-1:0]       o_ack;
  logic [N_REQ-1:0]       o_done;
  logic [QUO_W-1:0]       o_quotient;
  logic [DVS_W-1:0]       o_remainder;
  logic                   o_div_zero;
  logic                   o_ovf;
  logic                   o_busy;

  modport master (
    output i_req, i_dividend, i_divisor,
    input  o_ack, o_done, o_quotient, o_remainder, o_div_zero, o_ovf, o_busy
  );

  modport slave (
    input  i_req, i_dividend, i_divisor,
    output o_ack, o_done, o_quotient, o_remainder, o_div_zero, o_ovf, o_busy
  );

endinterface

// File: rtl/div_serial_core.sv
// Unsigned 32/16 restoring divider, one quotient bit per clock, fixed 32-cycle
// latency from i_start to the o_done pulse; zero divisor skips the iterations.
module div_serial_core
  import dist_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [DVD_W-1:0] i_dividend,
  input  logic [DVS_W-1:0] i_divisor,
  output logic             o_busy,
  output logic             o_done,
  output div_result_t      o_result
);

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DIV_ITER - 1);

  logic [DVD_W-1:0] r_quo;
  logic [DVS_W-1:0] r_rem;
  logic [DVS_W-1:0] r_dvs;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;
  logic             r_dz;

  logic [DVS_W:0]   w_trial;
  logic [DVS_W-1:0] w_diff;
  logic             w_fits;

  // Partial remainder stays below the divisor, so the difference fits DVS_W bits.
  always_comb begin
    w_trial = {r_rem, r_quo[DVD_W-1]};
    w_diff  = w_trial[DVS_W-1:0] - r_dvs;
    w_fits  = (w_trial >= {1'b0, r_dvs});
  end

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      // NOTE: the operand/shift registers are plain flops, so they are reset and read 0 after reset.
      r_quo  <= '0;
      r_rem  <= '0;
      r_dvs  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_dz   <= 1'b0;
    end else if (i_start) begin
      r_quo  <= i_dividend;
      r_rem  <= '0;
      r_dvs  <= i_divisor;
      r_dz   <= (i_divisor == '0);
      r_cnt  <= '0;
      r_busy <= 1'b1;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_busy) begin
        r_cnt <= r_cnt + CNT_W'(1);
        if (!r_dz) begin
          r_quo <= {r_quo[DVD_W-2:0], w_fits};
          r_rem <= w_fits ? w_diff : w_trial[DVS_W-1:0];
        end
        if (r_cnt == LAST_ITER) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  // With a zero divisor r_quo still holds the untouched dividend.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    o_result = '0;
    if (r_dz) begin
      o_result.quotient  = QUO_SAT;
      o_result.remainder = r_quo[DVS_W-1:0];
      o_result.div_zero  = 1'b1;
    end else if (|r_quo[DVD_W-1:QUO_W]) begin
      o_result.quotient  = QUO_SAT;
      o_result.remainder = r_rem;
      o_result.ovf       = 1'b1;
    end else begin
      o_result.quotient  = r_quo[QUO_W-1:0];
      o_result.remainder = r_rem;
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;

endmodule

// File: rtl/div_share_arbiter.sv
// Round-robin arbiter sharing one serial divider among N_REQ channels: grant,
// operand latch into the core, owner tracking and one-hot done demux.
module div_share_arbiter
  import dist_pkg::*;
#(
  parameter int N_REQ = 4
)
(
  input  logic               i_clk_50m,
  input  logic               i_rst,
  div_share_arbiter_if.slave bus
);

  localparam int                 PTR_W    = $clog2(N_REQ);
  localparam logic [PTR_W-1:0]   PTR_LAST = PTR_W'(N_REQ - 1);
  localparam logic [PTR_W:0]     N_EXT    = (PTR_W + 1)'(N_REQ);
  localparam logic [N_REQ-1:0]   ONE_HOT0 = N_REQ'(1);

  arb_state_e       r_state;
  arb_state_e       w_state_nxt;
  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] r_owner;
  logic [N_REQ-1:0] r_ack;
  logic [N_REQ-1:0] r_done;
  div_result_t      r_res;

  logic             w_gnt_vld;
  logic [PTR_W-1:0] w_gnt_idx;
  logic [PTR_W:0]   w_sum;
  logic [PTR_W-1:0] w_cand;
  logic             w_start;
  logic             w_finish;
  logic [DVD_W-1:0] w_sel_dvd;
  logic [DVS_W-1:0] w_sel_dvs;
  logic             w_core_busy;
  logic             w_core_done;
  div_result_t      w_core_res;

  // Descending scan so the requester closest to r_ptr is assigned last and wins.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    w_sum     = '0;
    w_cand    = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      w_sum = {1'b0, r_ptr} + (PTR_W + 1)'(i);
      if (w_sum >= N_EXT) w_sum = w_sum - N_EXT;
      w_cand = w_sum[PTR_W-1:0];
      if (bus.i_req[w_cand]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = w_cand;
      end
    end
  end

  assign w_sel_dvd = bus.i_dividend[int'(w_gnt_idx)*DVD_W +: DVD_W];
  assign w_sel_dvs = bus.i_divisor[int'(w_gnt_idx)*DVS_W +: DVS_W];

  div_serial_core u_core (
    .i_clk      (i_clk_50m),
    .i_rst      (i_rst),
    .i_start    (w_start),
    .i_dividend (w_sel_dvd),
    .i_divisor  (w_sel_dvs),
    .o_busy     (w_core_busy),
    .o_done     (w_core_done),
    .o_result   (w_core_res)
  );

  always_ff @(posedge i_clk_50m or posedge i_rst) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: if (w_gnt_vld)   w_state_nxt = ST_CALC;
      ST_CALC: if (w_core_done) w_state_nxt = ST_DONE;
      ST_DONE:                  w_state_nxt = ST_IDLE;
      default:                  w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_start  = 1'b0;
    w_finish = 1'b0;
    unique case (r_state)
      ST_IDLE: w_start  = w_gnt_vld;
      ST_DONE: w_finish = 1'b1;
      default: ;
    endcase
  end

  // Result buses are registered on leaving DONE and cleared in every other cycle.
  always_ff @(posedge i_clk_50m or posedge i_rst) begin
    if (i_rst) begin
      r_ptr   <= '0;
      r_owner <= '0;
      r_ack   <= '0;
      r_done  <= '0;
      r_res   <= '0;
    end else begin
      r_ack  <= '0;
      r_done <= '0;
      r_res  <= '0;
      if (w_start) begin
        r_ack   <= ONE_HOT0 << w_gnt_idx;
        r_owner <= w_gnt_idx;
        r_ptr   <= (w_gnt_idx == PTR_LAST) ? '0 : w_gnt_idx + PTR_W'(1);
      end
      if (w_finish) begin
        r_done <= ONE_HOT0 << r_owner;
        r_res  <= w_core_res;
      end
    end
  end

  assign bus.o_ack       = r_ack;
  assign bus.o_done      = r_done;
  assign bus.o_quotient  = r_res.quotient;
  assign bus.o_remainder = r_res.remainder;
  assign bus.o_div_zero  = r_res.div_zero;
  assign bus.o_ovf       = r_res.ovf;
  assign bus.o_busy      = (r_state != ST_IDLE) | (|r_done) | w_core_busy;

endmodule

// File: tb/tb_div_share_arbiter.sv
// Scoreboard bench for div_share_arbiter: a transaction-level model predicts grants
// and results; a monitor compares every o_ack / o_done pulse against it.
module tb_div_share_arbiter;
  import dist_pkg::*;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #10 clk = ~clk;

  div_share_arbiter_if #(.N_REQ(N)) bus ();

  div_share_arbiter #(.N_REQ(N)) dut (
    .i_clk_50m (clk),
    .i_rst     (rst),
    .bus       (bus)
  );

  typedef struct {
    int ch;
    int cyc;
  } ack_exp_t;

  typedef struct {
    int          ch;
    int          cyc;
    logic [15:0] q;
    logic [15:0] r;
    logic        dz;
    logic        ovf;
  } done_exp_t;

  ack_exp_t  ack_q[$];
  done_exp_t done_q[$];

  int n_cmp    = 0;
  int n_err    = 0;
  int cyc      = 0;
  int rr_ptr   = 0;
  int free_cyc = 0;
  bit rereq_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Plain-arithmetic reference for one division.
  function automatic done_exp_t ref_div(input int ch, input int at,
                                        input logic [31:0] a, input logic [15:0] b);
    done_exp_t   e;
    logic [31:0] full;
    e.ch  = ch;
    e.cyc = at;
    if (b == 16'd0) begin
      e.q   = 16'hFFFF;
      e.r   = a[15:0];
      e.dz  = 1'b1;
      e.ovf = 1'b0;
    end else begin
      full  = a / {16'd0, b};
      e.r   = 16'(a % {16'd0, b});
      e.dz  = 1'b0;
      e.ovf = (full > 32'd65535);
      e.q   = e.ovf ? 16'hFFFF : full[15:0];
    end
    return e;
  endfunction

  // Transaction model: a grant can happen once the previous operation's 35 clocks
  // have elapsed; the winner is the first requester from the round-robin pointer.
  initial forever begin
    @(posedge clk);
    cyc++;
    if (rst) begin
      rr_ptr   = 0;
      free_cyc = 0;
    end else if (cyc >= free_cyc && bus.i_req != '0) begin
      int       win;
      ack_exp_t ea;
      win = -1;
      for (int i = 0; i < N; i++)
        if (win < 0 && bus.i_req[(rr_ptr + i) % N]) win = (rr_ptr + i) % N;
      ea.ch  = win;
      ea.cyc = cyc;
      ack_q.push_back(ea);
      done_q.push_back(ref_div(win, cyc + 34, bus.i_dividend[win*32 +: 32],
                               bus.i_divisor[win*16 +: 16]));
      rr_ptr   = (win + 1) % N;
      free_cyc = cyc + 35;
    end
  end

  // Monitor: compares DUT pulses against the scoreboard queues.
  initial forever begin
    ack_exp_t    ea;
    done_exp_t   ed;
    logic [N-1:0] oh;
    @(negedge clk);
    if (!rst) begin
      check("ack_onehot", ($countones(bus.o_ack) <= 1), 1'b1);
      check("done_onehot", ($countones(bus.o_done) <= 1), 1'b1);
      if (bus.o_ack != '0) begin
        if (ack_q.size() == 0) check("ack_unexpected", bus.o_ack, '0);
        else begin
          ea = ack_q.pop_front();
          oh = '0;
          oh[ea.ch] = 1'b1;
          check("ack_channel", bus.o_ack, oh);
          check("ack_cycle", cyc, ea.cyc);
          check("busy_at_ack", bus.o_busy, 1'b1);
        end
      end
      if (bus.o_done != '0) begin
        if (done_q.size() == 0) check("done_unexpected", bus.o_done, '0);
        else begin
          ed = done_q.pop_front();
          oh = '0;
          oh[ed.ch] = 1'b1;
          check("done_channel", bus.o_done, oh);
          check("done_cycle", cyc, ed.cyc);
          check("quotient", bus.o_quotient, ed.q);
          check("remainder", bus.o_remainder, ed.r);
          check("div_zero", bus.o_div_zero, ed.dz);
          check("ovf", bus.o_ovf, ed.ovf);
          check("busy_at_done", bus.o_busy, 1'b1);
        end
      end else begin
        check("result_bus_idle",
              {bus.o_quotient, bus.o_remainder, bus.o_div_zero, bus.o_ovf}, '0);
      end
    end
  end

  task automatic post(input int ch, input logic [31:0] a, input logic [15:0] b);
    bus.i_dividend[ch*32 +: 32] = a;
    bus.i_divisor[ch*16 +: 16]  = b;
    bus.i_req[ch]               = 1'b1;
  endtask

  task automatic post_rand(input int ch);
    logic [31:0] a;
    logic [15:0] b;
    case ($urandom_range(0, 9))
      0:       b = 16'd0;
      1, 2, 3: b = 16'($urandom_range(1, 15));
      default: b = 16'($urandom);
    endcase
    a = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 32'h000F_FFFF);
    post(ch, a, b);
  endtask

  // One clock of requester behaviour: drop (or occasionally renew) an acked request.
  task automatic step();
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      if (bus.o_ack[k]) begin
        if (rereq_en && $urandom_range(0, 3) == 0) post_rand(k);
        else bus.i_req[k] = 1'b0;
      end
    end
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((bus.i_req != '0 || ack_q.size() != 0 || done_q.size() != 0) && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) begin
      n_cmp++;
      n_err++;
      $display("FAIL idle_timeout: still pending after %0d cycles, required idle", budget);
    end
  endtask

  task automatic wait_ack(input int ch, input int budget);
    int n;
    bit seen;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < budget) begin
      step();
      seen = bus.o_ack[ch];
      n++;
    end
    check("ack_seen", seen, 1'b1);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    bus.i_req = '0;
    #1;
    check("reset_outputs", {bus.o_ack, bus.o_done, bus.o_quotient, bus.o_remainder,
                            bus.o_div_zero, bus.o_ovf, bus.o_busy}, '0);
    ack_q.delete();
    done_q.delete();
    repeat (3) @(negedge clk);
    check("reset_held", {bus.o_ack, bus.o_done, bus.o_busy}, '0);
    rst = 1'b0;
  endtask

  initial begin
    #(1_000_000);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_req      = '0;
    bus.i_dividend = '0;
    bus.i_divisor  = '0;
    #1;
    do_reset();

    step(); post(0, 32'd1000, 16'd7);
    wait_idle(200);

    do_reset();
    step();
    for (int k = 0; k < N; k++) post(k, 32'(k), 16'(k + 1));
    wait_idle(400);

    step(); post(1, 32'd5000, 16'd3); post(3, 32'd77777, 16'd100);
    wait_idle(200);

    step(); post(2, 32'd123456, 16'd0);
    wait_idle(200);

    step(); post(0, 32'h0010_0000, 16'd1);
    wait_idle(200);

    // Grant ch2 so the pointer moves to 3, then abort mid-CALC.
    step(); post(2, 32'd600, 16'd7);
    wait_ack(2, 100);
    repeat (9) step();
    do_reset();
    step(); post(1, 32'd90, 16'd3); post(3, 32'd1234, 16'd5);
    wait_idle(200);

    rereq_en = 1'b1;
    repeat (2500) begin
      step();
      for (int k = 0; k < N; k++) begin
        if (!bus.i_req[k]) begin
          if ($urandom_range(0, 24) == 0) post_rand(k);
        end else if ($urandom_range(0, 299) == 0) begin
          bus.i_req[k] = 1'b0;
        end
      end
    end
    rereq_en = 1'b0;
    wait_idle(600);
    repeat (2) step();

    check("queues_drained", ack_q.size() + done_q.size(), 0);
    check("idle_busy", bus.o_busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
